stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
Command-side controller for the shift-cell stack chain. Accepts PUSH/POP/PEEK/NOP operations from the datapath over a valid/ready handshake, and drives the chain's push/pop/data_write/data_read strobes. Tracks depth, detects overflow and underflow, and returns the result over a second valid/ready handshake. Sits between the CPU stack-op decode and the shift-cell array.

Parameters:
WIDTH, 16, data word width (matches the cell width)
DEPTH, 16, number of cells in the chain
DEPTH_W, 5, width of the depth counter; must hold the value DEPTH, i.e. clog2(DEPTH+1)

Ports:
clk  in  1  single system clock, rising edge
async_reset  in  1  asynchronous, active-high reset
op_valid  in  1  operation request valid
op_code  in  2  00 NOP, 01 PUSH, 10 POP, 11 PEEK
op_data  in  WIDTH  push operand
op_ready  out  1  sequencer can accept an operation
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer takes the response
rsp_data  out  WIDTH  popped/peeked value; push echoes op_data; NOP returns 0
rsp_err  out  1  overflow or underflow
stk_push  out  1  push strobe to the chain
stk_pop  out  1  pop strobe to the chain
stk_data_write  out  1  write enable to the chain
stk_data_read  out  1  read enable to the chain
stk_data_in  out  WIDTH  value written into the top cell
stk_data_out  in  WIDTH  top-cell output from the chain
depth  out  DEPTH_W  current occupancy
full  out  1  depth == DEPTH
empty  out  1  depth == 0
hwm  out  DEPTH_W  high-water mark (see Optional Feature)

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - All strobes, rsp_valid, rsp_err, rsp_data, stk_data_in, depth and hwm are 0.
  - empty=1, full=0.
  - op_ready=1 once reset is released.
- FSM states: IDLE, ISSUE, CAPTURE, RESP. op_ready=1 only in IDLE.
- Accept: op_valid & op_ready at a rising edge. op_code and op_data are registered at that edge.
- From IDLE on accept:
  - PUSH while full → RESP with rsp_err=1.
  - POP/PEEK while empty → RESP with rsp_err=1, rsp_data=0.
  - NOP → RESP with rsp_err=0, rsp_data=0.
  - Otherwise → ISSUE.
  - Error and NOP paths issue no chain strobes and leave depth unchanged.
- ISSUE (exactly one cycle):
  - PUSH: stk_push=1, stk_data_write=1, stk_data_in=op_data; depth+1 at the end of the cycle; next state RESP with rsp_data=op_data.
  - POP/PEEK: stk_data_read=1; next state CAPTURE.
- CAPTURE (one cycle):
  - rsp_data is sampled from stk_data_out at the end of the cycle.
  - POP additionally drives stk_pop=1 and stk_data_read=1; depth-1 at the same edge.
  - PEEK drives stk_data_read=1 only.
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err stay stable until rsp_valid & rsp_ready.
  - On that handshake: → IDLE and rsp_valid=0 at the next edge.
- Latency from the accept edge to rsp_valid:
  - Error or NOP: 1 cycle.
  - PUSH: 2 cycles.
  - POP/PEEK: 3 cycles.
- Strobes are single-cycle pulses and are never asserted outside ISSUE or CAPTURE.
- Depth changes only at the edges named above; it never wraps. The full/empty guards make depth > DEPTH and depth < 0 unreachable.
- Only one operation is in flight at a time; there is no pipelining across operations.
- Reset mid-operation drops any active strobe asynchronously and discards the pending response. Stack contents are not tracked after reset (depth=0).

Optional Feature:
STACK_SEQ_HWM_EN
- Defined: hwm holds the maximum depth reached since reset. It is updated on the same edge as a depth increment and is never decremented.
- Undefined: the hwm port is tied to 0 and no register is built.

Decomposition:
- Package stack_pkg holds:
  - op code constants OP_NOP=2'b00, OP_PUSH=2'b01, OP_POP=2'b10, OP_PEEK=2'b11;
  - the FSM state encoding;
  - default WIDTH and DEPTH.
- One natural sub-module: stack_depth_counter. It owns depth, full, empty and hwm, with inc/dec inputs.

Test Plan:
- DEPTH=4. Reset, then PUSH 16'h1111 → stk_push, stk_data_write and stk_data_in=16'h1111 high for exactly 1 cycle; rsp_valid 2 cycles after accept; rsp_data=16'h1111; depth=1, empty=0.
- PUSH 1,2,3,4, then PUSH 5 → full=1 after the 4th push; the 5th returns rsp_err=1 in 1 cycle with no stk_push; depth stays 4.
- With the 4-cell chain model: PUSH 16'hA, PUSH 16'hB, PEEK → rsp_data=16'hB with depth 2. POP → 16'hB. POP → 16'hA. Then depth=0, empty=1, and stk_pop pulsed exactly twice.
- From reset, POP → rsp_err=1, rsp_data=0; no strobes; rsp_valid 1 cycle after accept.
- Hold rsp_ready=0 for 5 cycles after a PUSH → rsp_valid, rsp_data and rsp_err stable, op_ready=0 throughout; rsp_ready=1 → IDLE and op_ready=1 on the following cycle.
- Assert async_reset in the CAPTURE cycle of a POP → stk_pop and stk_data_read drop immediately; depth=0; no response; op_ready=1 after release. With STACK_SEQ_HWM_EN: hwm=0 after reset, hwm=4 after four pushes, and hwm stays 4 after pops.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op codes, FSM encoding and default sizes for the stack sequencer
package stack_pkg;

  localparam int STACK_WIDTH_DEF   = 16;
  localparam int STACK_DEPTH_DEF   = 16;
  localparam int STACK_DEPTH_W_DEF = 5;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } seq_state_e;

endpackage

// File: rtl/stack_depth_counter.sv
// rtl/stack_depth_counter.sv - occupancy counter with full/empty flags and optional high-water mark (STACK_SEQ_HWM_EN)
module stack_depth_counter
  import stack_pkg::*;
#(
  parameter int DEPTH   = STACK_DEPTH_DEF,
  parameter int DEPTH_W = STACK_DEPTH_W_DEF
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DEPTH_W-1:0] hwm_o
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  logic [DEPTH_W-1:0] depth_q, depth_d;

  assign full_o  = (depth_q == DEPTH_MAX);
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;

  // Guards keep the counter inside [0, DEPTH] even if a caller misbehaves.
  always_comb begin
    depth_d = depth_q;
    if (inc_i && !full_o) begin
      depth_d = depth_q + 1'b1;
    end else if (dec_i && !empty_o) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

`ifdef STACK_SEQ_HWM_EN
  logic [DEPTH_W-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (depth_d > hwm_q) begin
      hwm_d = depth_d;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm_o = hwm_q;
`else
  assign hwm_o = '0;
`endif

endmodule

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - command-side controller for the shift-cell stack chain (hwm gated by STACK_SEQ_HWM_EN)
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int WIDTH   = STACK_WIDTH_DEF,
  parameter int DEPTH   = STACK_DEPTH_DEF,
  parameter int DEPTH_W = STACK_DEPTH_W_DEF
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic               op_valid,
  input  logic [1:0]         op_code,
  input  logic [WIDTH-1:0]   op_data,
  output logic               op_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_data_write,
  output logic               stk_data_read,
  output logic [WIDTH-1:0]   stk_data_in,
  input  logic [WIDTH-1:0]   stk_data_out,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W-1:0] hwm
);

  seq_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             depth_inc, depth_dec;

  stack_depth_counter #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_depth (
    .clk         (clk),
    .async_reset (async_reset),
    .inc_i       (depth_inc),
    .dec_i       (depth_dec),
    .depth_o     (depth),
    .full_o      (full),
    .empty_o     (empty),
    .hwm_o       (hwm)
  );

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    data_d         = data_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    op_ready       = 1'b0;
    rsp_valid      = 1'b0;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    stk_data_write = 1'b0;
    stk_data_read  = 1'b0;
    stk_data_in    = '0;
    depth_inc      = 1'b0;
    depth_dec      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_d       = op_code;
          data_d     = op_data;
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          state_d    = ST_ISSUE;
          // Error and NOP requests answer directly without touching the chain.
          unique case (op_code)
            OP_NOP: state_d = ST_RESP;
            OP_PUSH: begin
              rsp_data_d = op_data;
              if (full) begin
                rsp_err_d = 1'b1;
                state_d   = ST_RESP;
              end
            end
            default: begin
              if (empty) begin
                rsp_err_d = 1'b1;
                state_d   = ST_RESP;
              end
            end
          endcase
        end
      end

      ST_ISSUE: begin
        if (op_q == OP_PUSH) begin
          stk_push       = 1'b1;
          stk_data_write = 1'b1;
          stk_data_in    = data_q;
          depth_inc      = 1'b1;
          state_d        = ST_RESP;
        end else begin
          stk_data_read = 1'b1;
          state_d       = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        stk_data_read = 1'b1;
        rsp_data_d    = stk_data_out;
        if (op_q == OP_POP) begin
          stk_pop   = 1'b1;
          depth_dec = 1'b1;
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - randomized self-checking bench for stack_sequencer against a queue model
module tb_stack_sequencer;
  import stack_pkg::*;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          async_reset;
  logic          op_valid;
  logic [1:0]    op_code;
  logic [W-1:0]  op_data;
  logic          op_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic          stk_push, stk_pop, stk_data_write, stk_data_read;
  logic [W-1:0]  stk_data_in;
  logic [W-1:0]  stk_data_out;
  logic [DW-1:0] depth;
  logic          full, empty;
  logic [DW-1:0] hwm;

  stack_sequencer #(.WIDTH(W), .DEPTH(D), .DEPTH_W(DW)) dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .op_valid       (op_valid),
    .op_code        (op_code),
    .op_data        (op_data),
    .op_ready       (op_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .stk_push       (stk_push),
    .stk_pop        (stk_pop),
    .stk_data_write (stk_data_write),
    .stk_data_read  (stk_data_read),
    .stk_data_in    (stk_data_in),
    .stk_data_out   (stk_data_out),
    .depth          (depth),
    .full           (full),
    .empty          (empty),
    .hwm            (hwm)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Shift-cell chain environment: top cell is cells[0].
  logic [W-1:0] cells [D];
  logic [W-1:0] last_win = '0;
  int n_push = 0, n_pop = 0, n_wr = 0, n_rd = 0;

  assign stk_data_out = cells[0];

  always @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      for (int i = 0; i < D; i++) cells[i] <= '0;
    end else begin
      if (stk_push) begin
        cells[0] <= stk_data_in;
        for (int i = 1; i < D; i++) cells[i] <= cells[i-1];
        last_win <= stk_data_in;
      end else if (stk_pop) begin
        for (int i = 0; i < D - 1; i++) cells[i] <= cells[i+1];
        cells[D-1] <= '0;
      end
      n_push <= n_push + (stk_push ? 1 : 0);
      n_pop  <= n_pop + (stk_pop ? 1 : 0);
      n_wr   <= n_wr + (stk_data_write ? 1 : 0);
      n_rd   <= n_rd + (stk_data_read ? 1 : 0);
    end
  end

  // Reference model: queue front is top of stack.
  logic [W-1:0] model_q [$];
  int hwm_model = 0;

  function automatic int exp_hwm();
`ifdef STACK_SEQ_HWM_EN
    return hwm_model;
`else
    return 0;
`endif
  endfunction

  task automatic do_op(input logic [1:0] code, input logic [W-1:0] d, input int hold);
    int lat, e_lat, e_push, e_pop, e_wr, e_rd;
    int b_push, b_pop, b_wr, b_rd;
    logic [W-1:0] e_data;
    logic e_err;

    lat = 0;
    while (!op_ready && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check_val("op_ready_before", op_ready, 1);

    e_lat = 1; e_err = 1'b0; e_data = '0;
    e_push = 0; e_pop = 0; e_wr = 0; e_rd = 0;
    case (code)
      OP_PUSH: begin
        e_data = d;
        if (model_q.size() == D) e_err = 1'b1;
        else begin
          model_q.push_front(d);
          e_lat = 2; e_push = 1; e_wr = 1;
          if (model_q.size() > hwm_model) hwm_model = model_q.size();
        end
      end
      OP_POP: begin
        if (model_q.size() == 0) e_err = 1'b1;
        else begin
          e_data = model_q.pop_front();
          e_lat = 3; e_pop = 1; e_rd = 2;
        end
      end
      OP_PEEK: begin
        if (model_q.size() == 0) e_err = 1'b1;
        else begin
          e_data = model_q[0];
          e_lat = 3; e_rd = 2;
        end
      end
      default: ;
    endcase

    b_push = n_push; b_pop = n_pop; b_wr = n_wr; b_rd = n_rd;
    op_valid = 1'b1; op_code = code; op_data = d;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 2'($urandom); op_data = W'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check_val("latency", lat, e_lat);
    check_val("rsp_valid", rsp_valid, 1);
    check_val("rsp_err", rsp_err, e_err);
    check_val("rsp_data", rsp_data, e_data);
    check_val("depth", depth, model_q.size());
    check_val("full", full, model_q.size() == D);
    check_val("empty", empty, model_q.size() == 0);
    check_val("hwm", hwm, exp_hwm());
    check_val("n_push", n_push - b_push, e_push);
    check_val("n_pop", n_pop - b_pop, e_pop);
    check_val("n_write", n_wr - b_wr, e_wr);
    check_val("n_read", n_rd - b_rd, e_rd);
    check_val("strobes_in_resp", {stk_push, stk_pop, stk_data_write, stk_data_read}, 0);
    check_val("op_ready_resp", op_ready, 0);
    if (e_push == 1) check_val("stk_data_in", last_win, d);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_val("hold_valid", rsp_valid, 1);
      check_val("hold_data", rsp_data, e_data);
      check_val("hold_err", rsp_err, e_err);
      check_val("hold_op_ready", op_ready, 0);
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("post_rsp_valid", rsp_valid, 0);
    check_val("post_op_ready", op_ready, 1);
  endtask

  task automatic random_ops(input int n);
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      c = ($urandom_range(0, 9) < 4) ? OP_PUSH : 2'($urandom_range(0, 3));
      do_op(c, W'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    async_reset = 1'b1;
    op_valid = 1'b0; op_code = OP_NOP; op_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_strobes", {stk_push, stk_pop, stk_data_write, stk_data_read}, 0);
    check_val("rst_rsp", {rsp_valid, rsp_err}, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_data_in", stk_data_in, 0);
    check_val("rst_depth", depth, 0);
    check_val("rst_hwm", hwm, 0);
    check_val("rst_flags", {full, empty}, 2'b01);
    async_reset = 1'b0;
    @(posedge clk); #1;
    check_val("rel_op_ready", op_ready, 1);

    do_op(OP_POP, 16'h0, 0);
    do_op(OP_PUSH, 16'h1111, 0);
    do_op(OP_PUSH, 16'h2, 0);
    do_op(OP_PUSH, 16'h3, 0);
    do_op(OP_PUSH, 16'h4, 0);
    do_op(OP_PUSH, 16'h5, 0);
    for (int i = 0; i < 4; i++) do_op(OP_POP, 16'h0, 0);
    do_op(OP_PUSH, 16'hA, 0);
    do_op(OP_PUSH, 16'hB, 0);
    do_op(OP_PEEK, 16'h0, 0);
    do_op(OP_POP, 16'h0, 0);
    do_op(OP_POP, 16'h0, 0);
    do_op(OP_PEEK, 16'h0, 0);
    do_op(OP_NOP, 16'hFFFF, 1);
    do_op(OP_PUSH, 16'hC0DE, 5);

    random_ops(150);

    while (model_q.size() == 0) do_op(OP_PUSH, W'($urandom), 0);
    op_valid = 1'b1; op_code = OP_POP; op_data = '0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    check_val("capture_pop", {stk_pop, stk_data_read}, 2'b11);
    async_reset = 1'b1;
    #1;
    check_val("mid_rst_strobes", {stk_push, stk_pop, stk_data_write, stk_data_read}, 0);
    check_val("mid_rst_depth", depth, 0);
    check_val("mid_rst_empty", empty, 1);
    check_val("mid_rst_hwm", hwm, 0);
    check_val("mid_rst_rsp_valid", rsp_valid, 0);
    model_q.delete();
    hwm_model = 0;
    @(posedge clk); #1;
    async_reset = 1'b0;
    @(posedge clk); #1;
    check_val("after_rst_op_ready", op_ready, 1);
    check_val("after_rst_rsp_valid", rsp_valid, 0);

    for (int i = 0; i < 4; i++) do_op(OP_PUSH, W'($urandom), 0);
    for (int i = 0; i < 3; i++) do_op(OP_POP, 16'h0, 0);
    random_ops(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
